// File: rtl/bit_inverter_if.sv
// -----------------------------------------------------------------------------
// bit_inverter_if
//   Stream bundle for the bit_inverter block: an input word channel and an
//   output word channel.
//
//   Handshake rule (both channels): a word moves across a channel on a rising
//   clock edge where valid and ready are both high. The sender holds data
//   and valid stable until that edge. The receiver may raise or lower ready
//   at any time. Data is meaningless while valid is low.
//
//   Signals
//     a          producer -> block     input word
//     in_valid   producer -> block     a holds a valid word
//     in_ready   block    -> producer  block accepts a word this cycle
//     b          block    -> consumer  inverted word
//     out_valid  block    -> consumer  b holds a valid word
//     out_ready  consumer -> block     consumer accepts b this cycle
//
//   Modports
//     slave   the bit_inverter side
//     master  the environment side (producer and consumer)
// -----------------------------------------------------------------------------
interface bit_inverter_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  a,
        input  in_valid,
        output in_ready,
        output b,
        output out_valid,
        input  out_ready
    );

    modport master (
        output a,
        output in_valid,
        input  in_ready,
        input  b,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/bit_inverter.sv
// -----------------------------------------------------------------------------
// bit_inverter
//   Streaming bitwise inverter. Every accepted input word x is delivered on b
//   as ~x. Words leave in the order they were accepted.
//
//   The block holds two entries:
//     - OUT, which drives b and out_valid
//     - SKID, which catches the one word that arrives in the same cycle the
//       consumer stalls
//   With these two entries, in_ready can come straight from a flop and the
//   block still moves one word per cycle.
//
//   Ports
//     clk   rising-edge clock
//     rst   asynchronous, active-high reset. The caller must release it
//           synchronously to clk.
//     bus   bit_inverter_if.slave. Carries a, in_valid, in_ready, b,
//           out_valid and out_ready.
// -----------------------------------------------------------------------------
module bit_inverter #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    bit_inverter_if.slave         bus
);

    // Registered state
    logic [WIDTH-1:0] out_data;
    logic             out_valid_q;
    logic [WIDTH-1:0] skid_data;
    logic             skid_full;
    logic             in_ready_q;

    // Next-state values
    logic [WIDTH-1:0] out_data_d;
    logic             out_valid_d;
    logic [WIDTH-1:0] skid_data_d;
    logic             skid_full_d;

    logic             in_xfer;
    logic             out_free;

    assign in_xfer  = bus.in_valid && in_ready_q;
    // OUT is free when it is empty or when its word is being taken this edge.
    assign out_free = !out_valid_q || bus.out_ready;

    always_comb begin
        out_data_d  = out_data;
        out_valid_d = out_valid_q;
        skid_data_d = skid_data;
        skid_full_d = skid_full;

        if (out_free) begin
            if (skid_full) begin
                // The older word in SKID goes out first to keep order.
                out_data_d  = skid_data;
                out_valid_d = 1'b1;
                if (in_xfer) begin
                    // Cannot happen while in_ready tracks !skid_full.
                    // Kept so SKID never drops a word.
                    skid_data_d = ~bus.a;
                    skid_full_d = 1'b1;
                end else begin
                    skid_full_d = 1'b0;
                end
            end else if (in_xfer) begin
                out_data_d  = ~bus.a;
                out_valid_d = 1'b1;
            end else begin
                // b keeps its last value. Only the valid flag drops.
                out_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            // OUT is stalled, so the arriving word parks in SKID.
            skid_data_d = ~bus.a;
            skid_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data    <= '0;
            out_valid_q <= 1'b0;
            skid_data   <= '0;
            skid_full   <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            out_data    <= out_data_d;
            out_valid_q <= out_valid_d;
            skid_data   <= skid_data_d;
            skid_full   <= skid_full_d;
            // in_ready comes from a flop. It is low only while SKID is
            // occupied, so any word accepted always has a slot.
            in_ready_q  <= !skid_full_d;
        end
    end

    assign bus.b         = out_data;
    assign bus.out_valid = out_valid_q;
    assign bus.in_ready  = in_ready_q;

endmodule

// File: tb/tb_bit_inverter.sv
// -----------------------------------------------------------------------------
// tb_bit_inverter
//   Directed and random checks for bit_inverter with WIDTH = 32.
//   Inputs change 1 time unit after each rising edge. Outputs are sampled at
//   that same point.
// -----------------------------------------------------------------------------
module tb_bit_inverter;

    localparam int W = 32;

    logic clk;
    logic rst;

    int n_cmp;
    int n_err;

    logic [W-1:0] exp_q[$];

    bit_inverter_if #(.WIDTH(W)) bus ();

    bit_inverter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs,
                         input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] b_prev;
        logic [W-1:0] exp_w;
        logic         in_x;
        logic         out_x;
        logic         hold;
        int           accepted;
        int           cycles;

        n_cmp = 0;
        n_err = 0;

        rst           = 1'b1;
        bus.a         = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;

        // 1. Reset, then idle
        tick();
        tick();
        tick();
        check("rst_b",         bus.b,         32'h0);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
        check("rst_in_ready",  {31'b0, bus.in_ready},  32'h0);
        rst = 1'b0;
        tick();
        check("rel_in_ready",  {31'b0, bus.in_ready},  32'h1);
        check("rel_out_valid", {31'b0, bus.out_valid}, 32'h0);

        // 2. Single words
        bus.a = 32'h0000_0000; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("single0_b",     bus.b,         32'hFFFF_FFFF);
        check("single0_valid", {31'b0, bus.out_valid}, 32'h1);
        tick();
        check("single0_empty", {31'b0, bus.out_valid}, 32'h0);

        bus.a = 32'hA5A5_0F0F; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("single1_b",     bus.b,         32'h5A5A_F0F0);
        check("single1_valid", {31'b0, bus.out_valid}, 32'h1);
        tick();
        check("single1_empty", {31'b0, bus.out_valid}, 32'h0);
        check("single1_hold_b", bus.b,        32'h5A5A_F0F0);

        // 3. Streaming, 8 back-to-back words
        for (int i = 0; i < 8; i++) begin
            check("stream_in_ready", {31'b0, bus.in_ready}, 32'h1);
            bus.a = W'(i); bus.in_valid = 1'b1;
            tick();
            check("stream_b",     bus.b,         32'hFFFF_FFFF - W'(i));
            check("stream_valid", {31'b0, bus.out_valid}, 32'h1);
        end
        bus.in_valid = 1'b0;
        tick();
        check("stream_empty", {31'b0, bus.out_valid}, 32'h0);

        // 4. Backpressure
        bus.out_ready = 1'b0;
        bus.a = 32'h1; bus.in_valid = 1'b1;
        tick();
        check("bp1_b",        bus.b,         32'hFFFF_FFFE);
        check("bp1_in_ready", {31'b0, bus.in_ready}, 32'h1);
        bus.a = 32'h2;
        tick();
        check("bp2_b",        bus.b,         32'hFFFF_FFFE);
        check("bp2_in_ready", {31'b0, bus.in_ready}, 32'h0);
        bus.a = 32'h3;
        tick();
        check("bp3_b",        bus.b,         32'hFFFF_FFFE);
        check("bp3_in_ready", {31'b0, bus.in_ready}, 32'h0);
        check("bp3_valid",    {31'b0, bus.out_valid}, 32'h1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("bp_drain1_b",     bus.b,         32'hFFFF_FFFD);
        check("bp_drain1_valid", {31'b0, bus.out_valid}, 32'h1);
        check("bp_drain1_ready", {31'b0, bus.in_ready},  32'h1);
        bus.a = 32'h3; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("bp_drain2_b",     bus.b,         32'hFFFF_FFFC);
        check("bp_drain2_valid", {31'b0, bus.out_valid}, 32'h1);
        tick();
        check("bp_drain_empty",  {31'b0, bus.out_valid}, 32'h0);

        // 5. Random stalls with scoreboard
        accepted = 0;
        cycles   = 0;
        while (accepted < 1000 && cycles < 8000) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.a         = $urandom;
            bus.out_ready = ($urandom_range(0, 2) != 0);
            in_x   = bus.in_valid && bus.in_ready;
            out_x  = bus.out_valid && bus.out_ready;
            hold   = bus.out_valid && !bus.out_ready;
            b_prev = bus.b;
            if (out_x) begin
                if (exp_q.size() == 0) begin
                    check("rnd_unexpected_out", {31'b0, bus.out_valid}, 32'h0);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("rnd_b", bus.b, exp_w);
                end
            end
            if (in_x) begin
                exp_q.push_back(~bus.a);
                accepted++;
            end
            tick();
            cycles++;
            if (hold) begin
                check("rnd_stable_b",     bus.b, b_prev);
                check("rnd_stable_valid", {31'b0, bus.out_valid}, 32'h1);
            end
        end
        check("rnd_accepted", W'(accepted), W'(1000));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cycles = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && cycles < 20) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("drain_unexpected_out", {31'b0, bus.out_valid}, 32'h0);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("drain_b", bus.b, exp_w);
                end
            end
            tick();
            cycles++;
        end
        check("drain_left", W'(exp_q.size()), W'(0));
        check("drain_valid", {31'b0, bus.out_valid}, 32'h0);

        // 6. Reset mid-operation, with both entries full
        bus.out_ready = 1'b0;
        bus.a = 32'hAAAA_0001; bus.in_valid = 1'b1;
        tick();
        bus.a = 32'hBBBB_0002;
        tick();
        bus.in_valid = 1'b0;
        check("full_valid",    {31'b0, bus.out_valid}, 32'h1);
        check("full_in_ready", {31'b0, bus.in_ready},  32'h0);
        check("full_b",        bus.b,         32'h5555_FFFE);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid",    {31'b0, bus.out_valid}, 32'h0);
        check("arst_b",        bus.b,         32'h0);
        check("arst_in_ready", {31'b0, bus.in_ready},  32'h0);
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("post_rst_in_ready", {31'b0, bus.in_ready},  32'h1);
        check("post_rst_valid",    {31'b0, bus.out_valid}, 32'h0);
        bus.a = 32'h1234_5678; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("post_rst_b",     bus.b,         32'hEDCB_A987);
        check("post_rst_valid1", {31'b0, bus.out_valid}, 32'h1);
        tick();
        check("post_rst_empty", {31'b0, bus.out_valid}, 32'h0);

        // ---------------- final report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
